// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the five-stage RV32I pipeline: resolves freeze, redirect and
// load-use hazards into register enables/flushes and tracks shadow cycles, errors and counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_stall_rs1,
  input  logic             ld_stall_rs2,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] busy_cnt
);

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_LD_BUBBLE    = 2'd1,
    ST_REDIR_SHADOW = 2'd2
  } state_t;

  localparam int                NUM_CNT = 3;
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  state_t           state_next;
  logic             hazard_err_reg;
  logic             hazard_err_next;
  logic             ld;
  logic             is_freeze;
  logic             is_redirect;
  logic             is_load;
  logic             err_detect;
  logic [NUM_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_reg  [NUM_CNT];
  logic [CNT_W-1:0] cnt_next [NUM_CNT];

  // Cycle classification, strict priority FREEZE > REDIRECT > LOAD > NORMAL.
  assign ld          = ld_stall_rs1 | ld_stall_rs2;
  assign is_freeze   = mem_busy;
  assign is_redirect = ~mem_busy & ex_redirect;
  assign is_load     = ~mem_busy & ~ex_redirect & ld;

  always_comb begin
    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    pc_target   = 32'd0;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    if (!rst_n) begin
      // Hold the whole pipeline and inject NOPs while reset is asserted.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (is_freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (is_redirect) begin
      pc_redirect = 1'b1;
      pc_target   = ex_target;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (is_load) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // A bubble in EX cannot cause a load-use, and a squashed shadow cannot redirect or stall.
  always_comb begin
    err_detect = 1'b0;
    if (!mem_busy) begin
      case (state_reg)
        ST_LD_BUBBLE:    err_detect = ld;
        ST_REDIR_SHADOW: err_detect = ld | ex_redirect;
        default:         err_detect = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next = ST_RUN;
    if (is_freeze) begin
      state_next = state_reg;
    end else if (is_redirect) begin
      state_next = ST_REDIR_SHADOW;
    end else if (is_load) begin
      state_next = ST_LD_BUBBLE;
    end
  end

  assign hazard_err_next = hazard_err_reg | err_detect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_RUN;
      hazard_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hazard_err_reg <= hazard_err_next;
    end
  end

  assign hazard_err = hazard_err_reg;

  // Counter slots: 0 = load-use bubbles, 1 = redirects, 2 = freeze cycles.
  assign cnt_inc = {is_freeze, is_redirect, is_load};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      assign cnt_next[gi] = cnt_clr     ? '0 :
                            cnt_inc[gi] ? cnt_reg[gi] + CNT_ONE :
                                          cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  assign stall_cnt = cnt_reg[0];
  assign flush_cnt = cnt_reg[1];
  assign busy_cnt  = cnt_reg[2];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second CNT_W=4 instance shares the
// stimulus and is used for the counter-wrap checks.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_stall_rs1 = 1'b0;
  logic        ld_stall_rs2 = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = 32'd0;
  logic        mem_busy = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, hazard_err;
  logic [31:0] pc_target, stall_cnt, flush_cnt, busy_cnt;

  logic        s_pc_en, s_pc_redirect, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush;
  logic        s_exmem_en, s_hazard_err;
  logic [31:0] s_pc_target;
  logic [3:0]  s_stall_cnt, s_flush_cnt, s_busy_cnt;

  int total = 0;
  int bad = 0;

  // {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
  logic [6:0] ctl;
  assign ctl = {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};

  localparam logic [6:0] C_NORMAL = 7'b1010101;
  localparam logic [6:0] C_REDIR  = 7'b1111111;
  localparam logic [6:0] C_LOAD   = 7'b0000111;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_RESET  = 7'b0001010;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ld_stall_rs1(ld_stall_rs1), .ld_stall_rs2(ld_stall_rs2),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .pc_target(pc_target), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .hazard_err(hazard_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy_cnt(busy_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .ld_stall_rs1(ld_stall_rs1), .ld_stall_rs2(ld_stall_rs2),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .pc_en(s_pc_en), .pc_redirect(s_pc_redirect), .pc_target(s_pc_target), .ifid_en(s_ifid_en),
    .ifid_flush(s_ifid_flush), .idex_en(s_idex_en), .idex_flush(s_idex_flush),
    .exmem_en(s_exmem_en), .hazard_err(s_hazard_err), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt), .busy_cnt(s_busy_cnt)
  );

  // Stimulus only: apply one cycle's inputs (called just after a rising edge).
  task automatic drive(input logic l1, input logic l2, input logic rd, input logic [31:0] tgt,
                       input logic busy, input logic clr);
    ld_stall_rs1 = l1;
    ld_stall_rs2 = l2;
    ex_redirect  = rd;
    ex_target    = tgt;
    mem_busy     = busy;
    cnt_clr      = clr;
    $display("[%0t] drive ld1=%0b ld2=%0b redir=%0b tgt=%h busy=%0b clr=%0b",
             $time, l1, l2, rd, tgt, busy, clr);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive(0, 0, 0, 32'd0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (ctl !== C_RESET) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET); end
    total++; if (pc_target !== 32'd0) begin bad++; $display("FAIL reset_tgt got=%h exp=0", pc_target); end
    total++; if (stall_cnt !== 0 || flush_cnt !== 0 || busy_cnt !== 0) begin bad++;
      $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", stall_cnt, flush_cnt, busy_cnt); end
    total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", hazard_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 32'd0, 0, 0);
    @(negedge clk);
    total++; if (ctl !== C_LOAD) begin bad++; $display("FAIL lu_ctl got=%b exp=%b", ctl, C_LOAD); end
    @(posedge clk); #1;
    total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_stall got=%0d exp=1", stall_cnt); end
    drive(0, 0, 0, 32'd0, 0, 0);
    @(negedge clk);
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL lu_next_ctl got=%b exp=%b", ctl, C_NORMAL); end
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL lu_err got=%b exp=0", hazard_err); end
    // Back in RUN: a new load-use is legal.
    drive(0, 1, 0, 32'd0, 0, 0);
    @(negedge clk);
    total++; if (ctl !== C_LOAD) begin bad++; $display("FAIL lu2_ctl got=%b exp=%b", ctl, C_LOAD); end
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b0 || stall_cnt !== 32'd2) begin bad++;
      $display("FAIL lu2_state got=err%b/cnt%0d exp=err0/cnt2", hazard_err, stall_cnt); end
    // Immediate repeat while EX holds the bubble is impossible.
    drive(1, 0, 0, 32'd0, 0, 0);
    @(negedge clk);
    total++; if (ctl !== C_LOAD) begin bad++; $display("FAIL lurep_ctl got=%b exp=%b", ctl, C_LOAD); end
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b1) begin bad++; $display("FAIL lurep_err got=%b exp=1", hazard_err); end
    $display("test_load_use done");
  endtask

  task automatic test_redirect();
    do_reset();
    drive(0, 1, 1, 32'h0000_0100, 0, 0);
    @(negedge clk);
    total++; if (ctl !== C_REDIR) begin bad++; $display("FAIL rd_ctl got=%b exp=%b", ctl, C_REDIR); end
    total++; if (pc_target !== 32'h100) begin bad++; $display("FAIL rd_tgt got=%h exp=00000100", pc_target); end
    @(posedge clk); #1;
    total++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin bad++;
      $display("FAIL rd_cnt got=flush%0d/stall%0d exp=flush1/stall0", flush_cnt, stall_cnt); end
    drive(0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    @(negedge clk);
    total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL rd_next_ctl got=%b exp=%b", ctl, C_NORMAL); end
    total++; if (pc_target !== 32'd0) begin bad++; $display("FAIL rd_next_tgt got=%h exp=0", pc_target); end
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL rd_err got=%b exp=0", hazard_err); end
    $display("test_redirect done");
  endtask

  task automatic test_freeze();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 32'h0000_0200, 1, 0);
      @(negedge clk);
      total++; if (ctl !== C_FREEZE || pc_target !== 32'd0) begin bad++;
        $display("FAIL frz_ctl[%0d] got=%b/%h exp=%b/0", i, ctl, pc_target, C_FREEZE); end
      @(posedge clk); #1;
    end
    total++; if (busy_cnt !== 32'd3 || flush_cnt !== 32'd0 || stall_cnt !== 32'd0) begin bad++;
      $display("FAIL frz_cnt got=%0d/%0d/%0d exp=3/0/0", busy_cnt, flush_cnt, stall_cnt); end
    drive(1, 0, 1, 32'h0000_0200, 0, 0);
    @(negedge clk);
    total++; if (ctl !== C_REDIR || pc_target !== 32'h200) begin bad++;
      $display("FAIL frz_rd got=%b/%h exp=%b/00000200", ctl, pc_target, C_REDIR); end
    @(posedge clk); #1;
    total++; if (flush_cnt !== 32'd1 || hazard_err !== 1'b0) begin bad++;
      $display("FAIL frz_rd_cnt got=flush%0d/err%b exp=flush1/err0", flush_cnt, hazard_err); end
    // Freeze inside the shadow holds state and must not flag.
    drive(1, 0, 1, 32'd0, 1, 0);
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b0 || busy_cnt !== 32'd4) begin bad++;
      $display("FAIL frz_shadow got=err%b/busy%0d exp=err0/busy4", hazard_err, busy_cnt); end
    // Still REDIR_SHADOW: a load-use now is an error.
    drive(1, 0, 0, 32'd0, 0, 0);
    @(negedge clk);
    total++; if (ctl !== C_LOAD) begin bad++; $display("FAIL frz_sh_ctl got=%b exp=%b", ctl, C_LOAD); end
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b1) begin bad++; $display("FAIL frz_sh_err got=%b exp=1", hazard_err); end
    $display("test_freeze done");
  endtask

  task automatic test_error();
    do_reset();
    drive(0, 0, 1, 32'h0000_0040, 0, 0);
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b0) begin bad++; $display("FAIL err_first got=%b exp=0", hazard_err); end
    drive(0, 0, 1, 32'h0000_0080, 0, 0);
    @(negedge clk);
    total++; if (ctl !== C_REDIR || pc_target !== 32'h80) begin bad++;
      $display("FAIL err_ctl got=%b/%h exp=%b/00000080", ctl, pc_target, C_REDIR); end
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b1 || flush_cnt !== 32'd2) begin bad++;
      $display("FAIL err_set got=err%b/flush%0d exp=err1/flush2", hazard_err, flush_cnt); end
    drive(0, 0, 0, 32'd0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", hazard_err); end
    drive(0, 0, 0, 32'd0, 0, 1);
    @(posedge clk); #1;
    total++; if (flush_cnt !== 0 || stall_cnt !== 0 || busy_cnt !== 0 || hazard_err !== 1'b1) begin bad++;
      $display("FAIL err_clr got=%0d/%0d/%0d err%b exp=0/0/0 err1", stall_cnt, flush_cnt, busy_cnt, hazard_err); end
    drive(0, 0, 0, 32'd0, 0, 0);
    $display("test_error done");
  endtask

  task automatic test_reset_mid();
    // Mid-LD_BUBBLE reset.
    do_reset();
    drive(1, 0, 0, 32'd0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 32'd0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ctl !== C_RESET) begin bad++; $display("FAIL rmid_ctl got=%b exp=%b", ctl, C_RESET); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 0, 0, 32'd0, 0, 0);
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b0 || stall_cnt !== 32'd1) begin bad++;
      $display("FAIL rmid_run got=err%b/stall%0d exp=err0/stall1", hazard_err, stall_cnt); end
    // Mid-REDIR_SHADOW reset.
    drive(0, 0, 1, 32'h0000_0300, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 32'h0000_0300, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ctl !== C_RESET || pc_target !== 32'd0) begin bad++;
      $display("FAIL rmid2_ctl got=%b/%h exp=%b/0", ctl, pc_target, C_RESET); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (hazard_err !== 1'b0 || flush_cnt !== 32'd1) begin bad++;
      $display("FAIL rmid2_run got=err%b/flush%0d exp=err0/flush1", hazard_err, flush_cnt); end
    drive(0, 0, 0, 32'd0, 0, 0);
    $display("test_reset_mid done");
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 32'd0, 0, 0);
      @(posedge clk); #1;
      if (i == 14) begin
        total++; if (s_stall_cnt !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d exp=15", s_stall_cnt); end
      end
      drive(0, 0, 0, 32'd0, 0, 0);
      @(posedge clk); #1;
    end
    total++; if (s_stall_cnt !== 4'd0 || stall_cnt !== 32'd16) begin bad++;
      $display("FAIL wrap_16 got=small%0d/wide%0d exp=small0/wide16", s_stall_cnt, stall_cnt); end
    total++; if (s_hazard_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b exp=0", s_hazard_err); end
    drive(0, 1, 0, 32'd0, 0, 1);
    @(negedge clk);
    total++; if (ctl !== C_LOAD) begin bad++; $display("FAIL wrapclr_ctl got=%b exp=%b", ctl, C_LOAD); end
    @(posedge clk); #1;
    total++; if (s_stall_cnt !== 4'd0 || stall_cnt !== 32'd0) begin bad++;
      $display("FAIL wrapclr_cnt got=small%0d/wide%0d exp=0/0", s_stall_cnt, stall_cnt); end
    drive(0, 0, 0, 32'd0, 0, 0);
    $display("test_counter_wrap done");
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_freeze();
    test_error();
    test_reset_mid();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
